// File: rtl/efpga_ci_if.sv
// Bundle of the core request/response channel and the eFPGA fabric signals.
// The slave modport is the bridge's view; master is the core plus fabric side.
interface efpga_ci_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_operand_a_i;
  logic [31:0] req_operand_b_i;
  logic [1:0]  req_operator_i;
  logic [3:0]  req_delay_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_timeout_o;
  logic [31:0] eFPGA_operand_a_o;
  logic [31:0] eFPGA_operand_b_o;
  logic [1:0]  eFPGA_operator_o;
  logic [3:0]  eFPGA_delay_o;
  logic        eFPGA_en_o;
  logic        eFPGA_write_strobe_o;
  logic [31:0] eFPGA_result_a_i;
  logic [31:0] eFPGA_result_b_i;
  logic [31:0] eFPGA_result_c_i;
  logic        eFPGA_fpga_done_i;

  modport slave (
    input  req_valid_i, req_operand_a_i, req_operand_b_i, req_operator_i, req_delay_i,
    input  rsp_ready_i, eFPGA_result_a_i, eFPGA_result_b_i, eFPGA_result_c_i, eFPGA_fpga_done_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_timeout_o,
    output eFPGA_operand_a_o, eFPGA_operand_b_o, eFPGA_operator_o, eFPGA_delay_o,
    output eFPGA_en_o, eFPGA_write_strobe_o
  );

  modport master (
    output req_valid_i, req_operand_a_i, req_operand_b_i, req_operator_i, req_delay_i,
    output rsp_ready_i, eFPGA_result_a_i, eFPGA_result_b_i, eFPGA_result_c_i, eFPGA_fpga_done_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_timeout_o,
    input  eFPGA_operand_a_o, eFPGA_operand_b_o, eFPGA_operator_o, eFPGA_delay_o,
    input  eFPGA_en_o, eFPGA_write_strobe_o
  );
endinterface

// File: rtl/efpga_ci_bridge.sv
// Single-outstanding handshake bridge from the Ibex custom-instruction port to the eFPGA.
// Optional done-mode timeout enabled by defining EFPGA_CI_TIMEOUT_EN.
module efpga_ci_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  efpga_ci_if.slave   bus
);

`ifdef EFPGA_CI_TIMEOUT_EN
  localparam int CNT_W = 16;
`else
  localparam int CNT_W = 4;
`endif

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("efpga_ci_bridge: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ready_reg;
  logic             rsp_valid_reg;
  logic [31:0]      result_reg;
  logic [31:0]      operand_a_reg;
  logic [31:0]      operand_b_reg;
  logic [1:0]       operator_reg;
  logic [3:0]       delay_reg;
  logic             en_reg;
  logic             strobe_reg;
  logic [31:0]      selected_result;
  logic             delay_hit;
  logic             done_hit;
  logic             timeout_hit;
  logic [CNT_W-1:0] count_load;

  always_comb begin
    selected_result = bus.eFPGA_result_a_i;
    case (operator_reg)
      2'd0: selected_result = bus.eFPGA_result_a_i;
      2'd1: selected_result = bus.eFPGA_result_b_i;
      2'd2: selected_result = bus.eFPGA_result_c_i;
      2'd3: selected_result = bus.eFPGA_result_a_i ^ bus.eFPGA_result_b_i;
      default: selected_result = bus.eFPGA_result_a_i;
    endcase
  end

  assign delay_hit = (delay_reg != 4'd0) && (count_reg == CNT_W'(1));
  // Done takes priority over an expiring timeout in the same cycle.
  assign done_hit  = (delay_reg == 4'd0) && bus.eFPGA_fpga_done_i;

`ifdef EFPGA_CI_TIMEOUT_EN
  logic timeout_reg;
  assign timeout_hit = (delay_reg == 4'd0) && !bus.eFPGA_fpga_done_i && (count_reg == CNT_W'(1));
  assign count_load  = (delay_reg != 4'd0) ? CNT_W'(delay_reg) : CNT_W'(TIMEOUT_CYCLES);
  assign bus.rsp_timeout_o = timeout_reg;
`else
  assign timeout_hit = 1'b0;
  assign count_load  = CNT_W'(delay_reg);
  assign bus.rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      result_reg    <= '0;
      operand_a_reg <= '0;
      operand_b_reg <= '0;
      operator_reg  <= '0;
      delay_reg     <= '0;
      en_reg        <= 1'b0;
      strobe_reg    <= 1'b0;
`ifdef EFPGA_CI_TIMEOUT_EN
      timeout_reg   <= 1'b0;
`endif
    end else begin
      strobe_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          if (ready_reg && bus.req_valid_i) begin
            operand_a_reg <= bus.req_operand_a_i;
            operand_b_reg <= bus.req_operand_b_i;
            operator_reg  <= bus.req_operator_i;
            delay_reg     <= bus.req_delay_i;
            ready_reg     <= 1'b0;
            strobe_reg    <= 1'b1;
            en_reg        <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          count_reg <= count_load;
          state_reg <= WAIT;
        end
        WAIT: begin
          count_reg <= count_reg - CNT_W'(1);
          if (delay_hit || done_hit) begin
            result_reg    <= selected_result;
            rsp_valid_reg <= 1'b1;
            en_reg        <= 1'b0;
            state_reg     <= RESP;
`ifdef EFPGA_CI_TIMEOUT_EN
            timeout_reg   <= 1'b0;
`endif
          end else if (timeout_hit) begin
            result_reg    <= '0;
            rsp_valid_reg <= 1'b1;
            en_reg        <= 1'b0;
            state_reg     <= RESP;
`ifdef EFPGA_CI_TIMEOUT_EN
            timeout_reg   <= 1'b1;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            ready_reg     <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o          = ready_reg;
  assign bus.rsp_valid_o          = rsp_valid_reg;
  assign bus.rsp_result_o         = result_reg;
  assign bus.eFPGA_operand_a_o    = operand_a_reg;
  assign bus.eFPGA_operand_b_o    = operand_b_reg;
  assign bus.eFPGA_operator_o     = operator_reg;
  assign bus.eFPGA_delay_o        = delay_reg;
  assign bus.eFPGA_en_o           = en_reg;
  assign bus.eFPGA_write_strobe_o = strobe_reg;

endmodule

// File: doc/efpga_ci_bridge.md
# efpga_ci_bridge

Handshake controller between the Ibex custom-instruction port and the eFPGA fabric in `design_2_top`. It accepts one operation at a time from the core: operands, operator and delay. It drives the `eFPGA_*` operand, operator, delay, enable and strobe signals. It then waits either a fixed delay or for `eFPGA_fpga_done_i`, captures the selected result and returns it to the core over a valid/ready response channel.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 256: maximum WAIT cycles in done-mode before abort. Legal range is 1..65535.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; low asserts.
- `req_valid_i`  in  1  core request valid.
- `req_ready_o`  out  1  bridge can accept a request.
- `req_operand_a_i`, `req_operand_b_i`  in  32 each  operands.
- `req_operator_i`  in  2  operation select.
- `req_delay_i`  in  4  fixed latency in cycles; 0 selects done-mode.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  core accepts the response.
- `rsp_result_o`  out  32  result.
- `rsp_timeout_o`  out  1  response was produced by timeout.
- `eFPGA_operand_a_o`, `eFPGA_operand_b_o`  out  32 each  registered operands.
- `eFPGA_operator_o`  out  2  registered operator.
- `eFPGA_delay_o`  out  4  registered delay.
- `eFPGA_en_o`  out  1  fabric enable.
- `eFPGA_write_strobe_o`  out  1  one-cycle operand-valid strobe.
- `eFPGA_result_a_i`, `eFPGA_result_b_i`, `eFPGA_result_c_i`  in  32 each  fabric results.
- `eFPGA_fpga_done_i`  in  1  fabric completion.

## Operation
FSM states are IDLE, ISSUE, WAIT and RESP.

- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`=1, register operands, operator and delay onto the `eFPGA_*` outputs, then go to ISSUE.
- **ISSUE** (1 cycle)
  - `eFPGA_write_strobe_o`=1 and `eFPGA_en_o`=1.
  - Load the counter: delay d when d≠0, otherwise `TIMEOUT_CYCLES`.
  - Go to WAIT.
- **WAIT**
  - `eFPGA_en_o`=1.
  - Delay-mode (d≠0): the counter decrements once per cycle. On the WAIT cycle where counter==1, capture the result and go to RESP. `eFPGA_fpga_done_i` is ignored.
  - Done-mode (d=0): on the first WAIT cycle with `eFPGA_fpga_done_i`=1, capture the result and go to RESP. A done pulse during ISSUE is ignored.
- **Result select by operator**
  - 0 → `eFPGA_result_a_i`
  - 1 → `eFPGA_result_b_i`
  - 2 → `eFPGA_result_c_i`
  - 3 → `eFPGA_result_a_i` XOR `eFPGA_result_b_i`
- **RESP**
  - `rsp_valid_o`=1.
  - `rsp_result_o` and `rsp_timeout_o` stay stable until `rsp_ready_i`=1.
  - On that handshake go to IDLE. The captured result is held on `rsp_result_o` until the next capture.
- `req_ready_o`=0 in every state except IDLE. There are no back-to-back overlaps and no request queue.
- `eFPGA_*` operand, operator and delay outputs hold their last values in IDLE.

## Timing
- **Reset values**: every output is 0 and the FSM is in IDLE. Reset takes effect immediately, including mid-operation; the in-flight operation is discarded and no response is produced.
- **Delay-mode latency**: request accepted at edge 0, ISSUE in cycle 1, WAIT in cycles 2..d+1, `rsp_valid_o` rises in cycle d+2.
- **Done-mode latency**: if done is first high in WAIT cycle t, `rsp_valid_o` is 1 in cycle t+1. The minimum is cycle 3.
- **Timeout** (when enabled): if done-mode sees no done for `TIMEOUT_CYCLES` WAIT cycles, go to RESP with `rsp_result_o`=0 and `rsp_timeout_o`=1.
- **Done coinciding with the final timeout cycle**: done wins; `rsp_timeout_o`=0.
- `rsp_ready_i` asserted before `rsp_valid_o` has no effect.
- `eFPGA_en_o` falls in the first RESP cycle.

## Configuration
- **`EFPGA_CI_TIMEOUT_EN` defined**: the done-mode timeout counter is present, with behaviour as described above.
- **Undefined**:
  - Done-mode waits indefinitely.
  - `rsp_timeout_o` is tied to 0.
  - The counter is 4 bits wide and used only for delay-mode.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- **Reset**: hold `reset`=0 → all outputs 0 and `req_ready_o`=1 after release. Assert reset during WAIT → outputs 0 immediately, and no `rsp_valid_o` afterwards.
- **Delay-mode**: a=5, b=7, op=0, d=3, result_a=0x1234 → one strobe pulse in cycle 1; `rsp_valid_o` in cycle 5 with result 0x1234 and timeout 0.
- **Done-mode**: d=0, op=3, result_a=0xF0F0_0000, result_b=0x0F0F_FFFF; done high in cycle 4 → `rsp_valid_o` in cycle 5 with result 0xFFFF_FFFF. A done pulse in cycle 1 must be ignored.
- **Backpressure**: `rsp_ready_i`=0 for 6 cycles → result stable and `req_ready_o`=0 throughout; the next request is accepted only after the handshake.
- **Timeout** (`EFPGA_CI_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=8): d=0, done never asserted → `rsp_valid_o` in cycle 10 with result 0 and timeout 1. Repeat with done in exactly the 8th WAIT cycle → timeout 0.
- **Operator sweep**: ops 1 and 2 with d=1 and distinct `eFPGA_result_b_i`/`eFPGA_result_c_i` values → correct selection; `rsp_valid_o` in cycle 3.
